stack_upstream_arbiter: RTL
===========================

// Module: stack_upstream_arbiter
// PURPOSE
//  Shares the single stack upstream (STI) bus between NUM_REQ PE-side message sources (e.g. SIMD upstream
//  interface, PE control/status). Arbitrates round-robin at message granularity; a grant is held from SOM
//  until the EOM beat is accepted, so messages are never interleaved. One registered output stage.
// PARAMETERS
//  NUM_REQ      2    number of requesters (2..4)
//  CNTL_W       2    width of cntl field (`COMMON_STD_INTF_CNTL_WIDTH)
//  TYPE_W       2    width of type field (`STACK_UP_INTF_TYPE_WIDTH)
//  DATA_W       64   width of data field (`STACK_UP_INTF_DATA_WIDTH)
//  OOB_W        16   width of oob_data field (`STACK_UP_INTF_OOB_DATA_WIDTH)
// PORTS
//  clk                 in   1              clock
//  reset_poweron       in   1              synchronous active-high reset
//  req__sua__valid     in   NUM_REQ        per-requester beat valid
//  req__sua__cntl      in   NUM_REQ*CNTL_W per-requester SOM/MOM/EOM/SOM_EOM (`COMMON_STD_INTF_CNTL_*)
//  req__sua__type      in   NUM_REQ*TYPE_W per-requester packet type
//  req__sua__data      in   NUM_REQ*DATA_W per-requester data
//  req__sua__oob_data  in   NUM_REQ*OOB_W  per-requester oob data (tag)
//  sua__req__ready     out  NUM_REQ        per-requester ready; beat accepted when valid&ready
//  sua__sti__valid     out  1              output beat valid
//  sua__sti__cntl      out  CNTL_W         output cntl
//  sua__sti__type      out  TYPE_W         output type
//  sua__sti__data      out  DATA_W         output data
//  sua__sti__oob_data  out  OOB_W          output oob data
//  sti__sua__ready     in   1              STI accepts beat when valid&ready (same cycle)
//  sua__grant          out  NUM_REQ        one-hot current owner (0 when idle)
//  sua__proto_error    out  1              sticky protocol error flag
// BEHAVIOUR
//  - Reset: all outputs 0, FSM=IDLE, rr pointer=0, output register empty. Reset mid-message drops the
//    partial message; no EOM is synthesised.
//  - Output stage: out_free = ~sua__sti__valid | sti__sui__ready. sua__req__ready[i] = grant[i] & out_free.
//    Accepted beat appears on sua__sti__* the next cycle (latency 1); held stable while valid & ~ready.
//  - FSM IDLE: requesters with valid & cntl in {SOM,SOM_EOM} are candidates; winner = first candidate at or
//    after rr pointer (wrapping). Grant asserted registered: winner owns bus from next cycle -> LOCKED.
//    No candidates -> stay IDLE, grant=0. Valid with MOM/EOM in IDLE is ignored (not accepted), sets error.
//  - FSM LOCKED: only owner may transfer. On accepted beat with cntl EOM or SOM_EOM: grant cleared,
//    rr pointer = owner+1 mod NUM_REQ, -> IDLE. Beat with SOM while LOCKED after first beat: accepted,
//    forwarded, sets error. Owner valid low: hold grant (bubbles allowed, no timeout).
//  - SOM_EOM single-beat message: one accepted beat, lock released the same cycle.
//  - Back-pressure: sti__sua__ready low holds output register; owner ready drops the same cycle.
//  - Arbitration cost: one dead cycle between messages (EOM accept -> IDLE -> next grant).
//  - sua__proto_error clears only on reset.
//  - Parameter check: NUM_REQ outside 2..4 is a elaboration-time $error.
// TESTING
//  1 Req0 sends 4-beat msg (SOM,MOM,MOM,EOM, data 1..4), sti ready=1 -> STI sees 1..4 on 4 consecutive
//    cycles starting 2 cycles after req0 valid, grant=01 throughout, then 00.
//  2 Req0 and req1 both present SOM same cycle, rr=0 -> req0 msg fully, then 1 idle cycle, then req1; next
//    simultaneous contest grants req1 first... no: rr=1 after req0, so req1 wins; verify alternation.
//  3 During req0 msg, req1 SOM pending and STI ready toggles 1,0,0,1 -> no req1 beat interleaves; output
//    beat held stable while ready=0; req0 ready low on those cycles.
//  4 Req1 SOM_EOM single beat (data 0xAB) -> one STI beat cntl SOM_EOM, grant 10 for one cycle, then idle.
//  5 Req0 presents MOM in IDLE -> never accepted, sua__proto_error=1 next cycle and stays 1 until reset.
//  6 Reset asserted mid-message (after beat 2 of 4) -> next cycle all outputs 0, grant 0; new SOM after
//    reset released is arbitrated normally from rr=0.

Source files
------------

// File: rtl/stack_upstream_arbiter.sv
// Round-robin arbiter sharing the stack upstream (STI) bus between NUM_REQ message sources.
// Grants are held for a whole message (SOM..EOM); one registered output stage toward STI.
module stack_upstream_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int CNTL_W  = 2,
  parameter int TYPE_W  = 2,
  parameter int DATA_W  = 64,
  parameter int OOB_W   = 16
) (
  input  logic                        clk,
  input  logic                        reset_poweron,
  input  logic [NUM_REQ-1:0]          req__sua__valid,
  input  logic [NUM_REQ*CNTL_W-1:0]   req__sua__cntl,
  input  logic [NUM_REQ*TYPE_W-1:0]   req__sua__type,
  input  logic [NUM_REQ*DATA_W-1:0]   req__sua__data,
  input  logic [NUM_REQ*OOB_W-1:0]    req__sua__oob_data,
  output logic [NUM_REQ-1:0]          sua__req__ready,
  output logic                        sua__sti__valid,
  output logic [CNTL_W-1:0]           sua__sti__cntl,
  output logic [TYPE_W-1:0]           sua__sti__type,
  output logic [DATA_W-1:0]           sua__sti__data,
  output logic [OOB_W-1:0]            sua__sti__oob_data,
  input  logic                        sti__sua__ready,
  output logic [NUM_REQ-1:0]          sua__grant,
  output logic                        sua__proto_error
);

  localparam int IDX_W = (NUM_REQ > 2) ? 2 : 1;

  localparam logic [CNTL_W-1:0] CNTL_MOM     = CNTL_W'(0);
  localparam logic [CNTL_W-1:0] CNTL_SOM     = CNTL_W'(1);
  localparam logic [CNTL_W-1:0] CNTL_EOM     = CNTL_W'(2);
  localparam logic [CNTL_W-1:0] CNTL_SOM_EOM = CNTL_W'(3);

  if (NUM_REQ < 2 || NUM_REQ > 4) begin : g_bad_num_req
    $error("stack_upstream_arbiter: NUM_REQ must be in 2..4");
  end

  typedef enum logic {ST_IDLE, ST_LOCKED} state_t;

  state_t               state_q, state_d;
  logic [IDX_W-1:0]     owner_q, owner_d;
  logic [IDX_W-1:0]     rr_q, rr_d;
  logic [NUM_REQ-1:0]   grant_q, grant_d;
  logic                 first_q, first_d;
  logic                 err_q, err_d;

  logic [NUM_REQ-1:0]   cand;
  logic [NUM_REQ-1:0]   ready_vec;
  logic                 out_free;
  logic                 accept;
  logic                 win_found;
  logic [IDX_W-1:0]     win_idx;
  int                   scan_idx;

  logic [CNTL_W-1:0]    own_cntl;
  logic [TYPE_W-1:0]    own_type;
  logic [DATA_W-1:0]    own_data;
  logic [OOB_W-1:0]     own_oob;

  logic                 out_valid_q;
  logic [CNTL_W-1:0]    out_cntl_q;
  logic [TYPE_W-1:0]    out_type_q;
  logic [DATA_W-1:0]    out_data_q;
  logic [OOB_W-1:0]     out_oob_q;

  function automatic logic is_start(input logic [CNTL_W-1:0] c);
    return (c == CNTL_SOM) || (c == CNTL_SOM_EOM);
  endfunction

  function automatic logic is_end(input logic [CNTL_W-1:0] c);
    return (c == CNTL_EOM) || (c == CNTL_SOM_EOM);
  endfunction

  // Only the owner can see ready, and only while the output register can take a beat.
  always_comb begin
    out_free  = ~out_valid_q | sti__sua__ready;
    ready_vec = grant_q & {NUM_REQ{out_free}};
    accept    = |(req__sua__valid & ready_vec);
    own_cntl  = req__sua__cntl[int'(owner_q)*CNTL_W +: CNTL_W];
    own_type  = req__sua__type[int'(owner_q)*TYPE_W +: TYPE_W];
    own_data  = req__sua__data[int'(owner_q)*DATA_W +: DATA_W];
    own_oob   = req__sua__oob_data[int'(owner_q)*OOB_W +: OOB_W];
  end

  always_comb begin
    cand = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand[i] = req__sua__valid[i] && is_start(req__sua__cntl[i*CNTL_W +: CNTL_W]);
    end
  end

  // Scan starts at the round-robin pointer and wraps; first candidate found wins.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    scan_idx  = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      scan_idx = (int'(rr_q) + k) % NUM_REQ;
      if (!win_found && cand[scan_idx]) begin
        win_found = 1'b1;
        win_idx   = IDX_W'(scan_idx);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    rr_d    = rr_q;
    grant_d = grant_q;
    first_d = first_q;
    err_d   = err_q;
    case (state_q)
      ST_IDLE: begin
        if (|(req__sua__valid & ~cand)) begin
          err_d = 1'b1;
        end
        if (win_found) begin
          state_d = ST_LOCKED;
          owner_d = win_idx;
          grant_d = NUM_REQ'(1) << win_idx;
          first_d = 1'b1;
        end
      end
      ST_LOCKED: begin
        if (accept) begin
          first_d = 1'b0;
          // A fresh SOM inside an open message is still forwarded but flagged.
          if (own_cntl == CNTL_SOM && !first_q) begin
            err_d = 1'b1;
          end
          if (is_end(own_cntl)) begin
            state_d = ST_IDLE;
            grant_d = '0;
            rr_d    = (owner_q == IDX_W'(NUM_REQ - 1)) ? '0 : owner_q + IDX_W'(1);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset_poweron) begin
      state_q <= ST_IDLE;
      owner_q <= '0;
      rr_q    <= '0;
      grant_q <= '0;
      first_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      rr_q    <= rr_d;
      grant_q <= grant_d;
      first_q <= first_d;
      err_q   <= err_d;
    end
  end

  // Output register holds its beat under back-pressure and empties once STI takes it.
  always_ff @(posedge clk) begin
    if (reset_poweron) begin
      out_valid_q <= 1'b0;
      out_cntl_q  <= '0;
      out_type_q  <= '0;
      out_data_q  <= '0;
      out_oob_q   <= '0;
    end else if (accept) begin
      out_valid_q <= 1'b1;
      out_cntl_q  <= own_cntl;
      out_type_q  <= own_type;
      out_data_q  <= own_data;
      out_oob_q   <= own_oob;
    end else if (sti__sua__ready) begin
      out_valid_q <= 1'b0;
    end
  end

  assign sua__req__ready    = ready_vec;
  assign sua__sti__valid    = out_valid_q;
  assign sua__sti__cntl     = out_cntl_q;
  assign sua__sti__type     = out_type_q;
  assign sua__sti__data     = out_data_q;
  assign sua__sti__oob_data = out_oob_q;
  assign sua__grant         = grant_q;
  assign sua__proto_error   = err_q;

  logic unused_mom;
  assign unused_mom = ^CNTL_MOM;

endmodule
